// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: op-codes (also used by decode),
// FSM states and the divider step count.
package mdu_pkg;

  localparam int DIV_STEPS = 32;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } mdu_state_t;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Iterative restoring divider: one quotient bit per step on operand magnitudes,
// sign fix and divide-by-zero result applied to the final-step outputs.
module div_core
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        step,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        last,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] r_q, r_d;
  logic [31:0] raw_q, raw_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dvz_q, dvz_d;

  logic [32:0] trial;
  logic        fits;
  logic [31:0] a_next;
  logic [31:0] r_next;

  always_comb begin
    trial  = {r_q, a_q[31]} - {1'b0, b_q};
    fits   = ~trial[32];
    r_next = fits ? trial[31:0] : {r_q[30:0], a_q[31]};
    a_next = {a_q[30:0], fits};
    last   = (cnt_q == 5'(DIV_STEPS - 1));
  end

  // The final step's results go straight to HI/LO, so the fix-up works on a_next/r_next.
  always_comb begin
    if (dvz_q) begin
      quotient  = 32'hFFFF_FFFF;
      remainder = raw_q;
    end else begin
      quotient  = neg_quo_q ? (~a_next + 32'd1) : a_next;
      remainder = neg_rem_q ? (~r_next + 32'd1) : r_next;
    end
  end

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    r_d       = r_q;
    raw_d     = raw_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dvz_d     = dvz_q;
    if (start) begin
      a_d       = abs32(dividend, is_signed);
      b_d       = abs32(divisor, is_signed);
      r_d       = 32'd0;
      raw_d     = dividend;
      cnt_d     = 5'd0;
      neg_quo_d = is_signed & (dividend[31] ^ divisor[31]);
      neg_rem_d = is_signed & dividend[31];
      dvz_d     = (divisor == 32'd0);
    end else if (step) begin
      a_d   = a_next;
      r_d   = r_next;
      cnt_d = cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      r_q       <= 32'd0;
      raw_q     <= 32'd0;
      cnt_q     <= 5'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dvz_q     <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      r_q       <= r_d;
      raw_q     <= raw_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dvz_q     <= dvz_d;
    end
  end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit owning HI/LO: one-cycle MULT/MULTU, 32-step DIV/DIVU,
// immediate MTHI/MTLO.
//   state | meaning
//   IDLE  | ready for an op; MTHI/MTLO complete here
//   MUL   | product of latched operands written to HI/LO
//   DIV   | div_core stepping; last step writes HI/LO
module mdu
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_t  state_q, state_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic        mul_signed_q, mul_signed_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        accept;
  logic        div_start;
  logic        div_step;
  logic        div_last;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic [63:0] product;

  assign accept    = req_valid & (state_q == IDLE) & ~flush;
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign hi        = hi_q;
  assign lo        = lo_q;

  // Sign-extend only for MULT; the low 64 bits of the wide product are right either way.
  assign product = {{32{mul_signed_q & op1_q[31]}}, op1_q} *
                   {{32{mul_signed_q & op2_q[31]}}, op2_q};

  div_core u_div_core (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_start),
    .step      (div_step),
    .is_signed (req_op == OP_DIV),
    .dividend  (in1),
    .divisor   (in2),
    .last      (div_last),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d      = state_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    mul_signed_d = mul_signed_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    done         = 1'b0;
    div_start    = 1'b0;
    div_step     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (req_op)
            OP_MULT, OP_MULTU: begin
              state_d      = MUL;
              op1_d        = in1;
              op2_d        = in2;
              mul_signed_d = (req_op == OP_MULT);
            end
            OP_DIV, OP_DIVU: begin
              state_d   = DIV;
              op1_d     = in1;
              op2_d     = in2;
              div_start = 1'b1;
            end
            OP_MTHI: begin
              hi_d = in1;
              done = 1'b1;
            end
            OP_MTLO: begin
              lo_d = in1;
              done = 1'b1;
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        state_d = IDLE;
        if (!flush) begin
          hi_d = product[63:32];
          lo_d = product[31:0];
          done = 1'b1;
        end
      end
      DIV: begin
        div_step = ~flush;
        if (flush) begin
          state_d = IDLE;
        end else if (div_last) begin
          state_d = IDLE;
          hi_d    = div_rem;
          lo_d    = div_quo;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      op1_q        <= 32'd0;
      op2_q        <= 32'd0;
      mul_signed_q <= 1'b0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
    end else begin
      state_q      <= state_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      mul_signed_q <= mul_signed_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
    end
  end

endmodule
